riscv_lsu_multi_outstanding: RTL and testbench

Parametrised load-store unit between the EX/WB stages and the data memory port.
- Supports up to NUM_OUTSTANDING granted-but-unanswered memory beats.
- Splits misaligned word and halfword accesses into two aligned beats internally, so the controller does not stall for them.
- Reassembles and sign-extends read data from a per-beat tracking FIFO.
- Returns one registered response per EX request, in order.

---
 rtl/riscv_lsu_multi_outstanding.sv | 227 ++++++++++++++++++++++
 tb/tb_riscv_lsu_multi_outstanding.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu_multi_outstanding.sv
// Load-store unit: issues word-aligned memory beats (splitting misaligned accesses in two),
// tracks up to NUM_OUTSTANDING granted beats and returns one registered response per request.
module riscv_lsu_multi_outstanding #(
    parameter int NUM_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(NUM_OUTSTANDING + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [1:0]       req_type_i,
    input  logic [1:0]       req_sign_ext_i,
    input  logic [31:0]      req_addr_i,
    input  logic [31:0]      req_wdata_i,
    output logic             data_req_o,
    input  logic             data_gnt_i,
    output logic [31:0]      data_addr_o,
    output logic             data_we_o,
    output logic [3:0]       data_be_o,
    output logic [31:0]      data_wdata_o,
    input  logic             data_rvalid_i,
    input  logic             data_err_i,
    input  logic [31:0]      data_rdata_i,
    output logic             resp_valid_o,
    output logic [31:0]      resp_rdata_o,
    output logic             resp_err_o,
    output logic             resp_we_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             busy_o
);
    localparam int               PTR_W    = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(NUM_OUTSTANDING);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_OUTSTANDING - 1);

    typedef enum logic {ISSUE1, ISSUE2} state_e;
    typedef enum logic [1:0] {KIND_REG, KIND_FIRST, KIND_SECOND} kind_e;

    typedef struct packed {
        logic [3:0] mask;
        logic [1:0] off;
        logic [1:0] typ;
        logic [1:0] sext;
        logic       we;
        kind_e      kind;
    } trk_t;

    state_e           state_q, state_d;
    trk_t             mem_q [NUM_OUTSTANDING];
    trk_t             mem_d [NUM_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      partial_q, partial_d;
    logic             err_acc_q, err_acc_d;
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_rdata_q, resp_rdata_d;
    logic             resp_err_q, resp_err_d;
    logic             resp_we_q, resp_we_d;

    logic [1:0]  off;
    logic [4:0]  rot_sh;
    logic [3:0]  base_be;
    logic [7:0]  be8;
    logic        misaligned;
    logic        not_full;
    logic        push;
    logic        pop;
    trk_t        push_entry;
    trk_t        head;
    logic [31:0] masked;
    logic [31:0] lo;
    logic [31:0] d;
    logic        ext;
    logic        err_now;

    always_comb begin
        off    = req_addr_i[1:0];
        rot_sh = {off, 3'b000};
        if (req_type_i[1]) begin
            base_be = 4'b0001;
        end else if (req_type_i[0]) begin
            base_be = 4'b0011;
        end else begin
            base_be = 4'b1111;
        end
        be8          = {4'b0000, base_be} << off;
        misaligned   = ((req_type_i == 2'b00) && (off != 2'b00)) ||
                       ((req_type_i == 2'b01) && (off == 2'b11));
        data_wdata_o = (req_wdata_i << rot_sh) | (req_wdata_i >> (6'd32 - {1'b0, rot_sh}));
        data_we_o    = req_we_i;
    end

    // Issue FSM: the second beat of a split is already committed, so it ignores req_valid_i.
    always_comb begin
        state_d         = state_q;
        not_full        = count_q < MAX_CNT;
        data_req_o      = 1'b0;
        req_ready_o     = 1'b0;
        data_addr_o     = {req_addr_i[31:2], 2'b00};
        data_be_o       = be8[3:0];
        push_entry.mask = be8[3:0];
        push_entry.off  = off;
        push_entry.typ  = req_type_i;
        push_entry.sext = req_sign_ext_i;
        push_entry.we   = req_we_i;
        push_entry.kind = misaligned ? KIND_FIRST : KIND_REG;
        case (state_q)
            ISSUE1: begin
                data_req_o = req_valid_i && not_full;
                if (data_req_o && data_gnt_i) begin
                    if (misaligned) begin
                        state_d = ISSUE2;
                    end else begin
                        req_ready_o = 1'b1;
                    end
                end
            end
            ISSUE2: begin
                data_req_o      = not_full;
                data_addr_o     = {req_addr_i[31:2], 2'b00} + 32'd4;
                data_be_o       = be8[7:4];
                push_entry.mask = be8[7:4];
                push_entry.kind = KIND_SECOND;
                if (data_req_o && data_gnt_i) begin
                    req_ready_o = 1'b1;
                    state_d     = ISSUE1;
                end
            end
            default: state_d = ISSUE1;
        endcase
    end

    always_comb begin
        push     = data_req_o && data_gnt_i;
        pop      = data_rvalid_i && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_comb begin
        head = mem_q[rd_ptr_q];
        for (int i = 0; i < 4; i++) begin
            masked[8*i +: 8] = data_rdata_i[8*i +: 8] & {8{head.mask[i]}};
        end
        lo      = masked >> {head.off, 3'b000};
        d       = lo;
        err_now = data_err_i;
        if (head.kind == KIND_SECOND) begin
            d       = partial_q | (masked << {3'd4 - {1'b0, head.off}, 3'b000});
            err_now = err_acc_q | data_err_i;
        end
        case (head.sext)
            2'b00:   ext = 1'b0;
            2'b10:   ext = 1'b1;
            default: ext = head.typ[1] ? d[7] : d[15];
        endcase
        if (head.typ[1]) begin
            d[31:8] = {24{ext}};
        end else if (head.typ[0]) begin
            d[31:16] = {16{ext}};
        end

        partial_d    = partial_q;
        err_acc_d    = err_acc_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        resp_we_d    = resp_we_q;
        if (pop) begin
            if (head.kind == KIND_FIRST) begin
                partial_d = lo;
                err_acc_d = data_err_i;
            end else begin
                resp_valid_d = 1'b1;
                resp_rdata_d = head.we ? 32'd0 : d;
                resp_err_d   = err_now;
                resp_we_d    = head.we;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ISSUE1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            partial_q    <= '0;
            err_acc_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            partial_q    <= partial_d;
            err_acc_q    <= err_acc_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            resp_we_q    <= resp_we_d;
        end
    end

    assign resp_valid_o  = resp_valid_q;
    assign resp_rdata_o  = resp_rdata_q;
    assign resp_err_o    = resp_err_q;
    assign resp_we_o     = resp_we_q;
    assign outstanding_o = count_q;
    assign busy_o        = (count_q != '0) || data_req_o || resp_valid_q;
endmodule

// File: tb/tb_riscv_lsu_multi_outstanding.sv
// Bench for riscv_lsu_multi_outstanding: directed vector table, hand sequences for
// back-to-back / reset corners, and a randomized run against a byte-level memory model.
module tb_riscv_lsu_multi_outstanding;
    localparam int N  = 2;
    localparam int CW = $clog2(N + 1);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i, req_ready_o, req_we_i;
    logic [1:0]    req_type_i, req_sign_ext_i;
    logic [31:0]   req_addr_i, req_wdata_i;
    logic          data_req_o, data_gnt_i, data_we_o;
    logic [31:0]   data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]    data_be_o;
    logic          data_rvalid_i, data_err_i;
    logic          resp_valid_o, resp_err_o, resp_we_o, busy_o;
    logic [31:0]   resp_rdata_o;
    logic [CW-1:0] outstanding_o;

    always #5 clk_i = ~clk_i;

    riscv_lsu_multi_outstanding #(.NUM_OUTSTANDING(N)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_type_i(req_type_i), .req_sign_ext_i(req_sign_ext_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
        .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_rdata_i(data_rdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .resp_we_o(resp_we_o), .outstanding_o(outstanding_o), .busy_o(busy_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic err_word(input logic [31:0] wa);
        return (wa[11:2] % 10'd13) == 10'd5;
    endfunction

    function automatic int nbytes(input logic [1:0] typ);
        return typ[1] ? 1 : (typ[0] ? 2 : 4);
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Expected {we, err, rdata}: gather the addressed bytes little-endian, then extend.
    function automatic logic [33:0] model(input logic we, input logic [1:0] typ,
                                          input logic [1:0] sext, input logic [31:0] addr);
        logic [31:0] val = 32'd0;
        logic        err = 1'b0;
        logic [31:0] a;
        logic [31:0] w;
        logic        ext;
        int          n = nbytes(typ);
        for (int i = 0; i < n; i++) begin
            a = addr + i;
            w = mem_word({a[31:2], 2'b00});
            val[8*i +: 8] = w[8*a[1:0] +: 8];
            err |= err_word({a[31:2], 2'b00});
        end
        ext = (sext == 2'b00) ? 1'b0 : ((sext == 2'b10) ? 1'b1 : val[8*n-1]);
        for (int i = 8 * n; i < 32; i++) val[i] = ext;
        return {we, err, we ? 32'd0 : val};
    endfunction

    typedef struct {
        logic        we;
        logic [1:0]  typ;
        logic [1:0]  sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd1;
        logic        err1;
        logic [31:0] rd2;
        logic        err2;
        int          beats;
        logic [31:0] a1;
        logic [3:0]  be1;
        logic [31:0] a2;
        logic [3:0]  be2;
        logic [31:0] exp_wd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic apply_vec(input int idx, input vec_t v);
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = v.we; req_type_i = v.typ; req_sign_ext_i = v.sext;
        req_addr_i = v.addr; req_wdata_i = v.wdata;
        data_gnt_i = 1'b1; data_rvalid_i = 1'b0;
        #1;
        check($sformatf("v%0d_req1", idx), data_req_o, 1'b1);
        check($sformatf("v%0d_addr1", idx), data_addr_o, v.a1);
        check($sformatf("v%0d_be1", idx), data_be_o, v.be1);
        check($sformatf("v%0d_we", idx), data_we_o, v.we);
        check($sformatf("v%0d_wdata1", idx), data_wdata_o, v.exp_wd);
        check($sformatf("v%0d_ready1", idx), req_ready_o, v.beats == 1);
        if (v.beats == 2) begin
            @(negedge clk_i);
            req_valid_i = 1'b0;
            data_rvalid_i = 1'b1; data_rdata_i = v.rd1; data_err_i = v.err1;
            #1;
            check($sformatf("v%0d_req2", idx), data_req_o, 1'b1);
            check($sformatf("v%0d_addr2", idx), data_addr_o, v.a2);
            check($sformatf("v%0d_be2", idx), data_be_o, v.be2);
            check($sformatf("v%0d_wdata2", idx), data_wdata_o, v.exp_wd);
            check($sformatf("v%0d_ready2", idx), req_ready_o, 1'b1);
            @(negedge clk_i);
            data_gnt_i = 1'b0; data_rdata_i = v.rd2; data_err_i = v.err2;
        end else begin
            @(negedge clk_i);
            req_valid_i = 1'b0; data_gnt_i = 1'b0;
            data_rvalid_i = 1'b1; data_rdata_i = v.rd1; data_err_i = v.err1;
        end
        #1;
        check($sformatf("v%0d_no_early_resp", idx), resp_valid_o, 1'b0);
        @(negedge clk_i);
        data_rvalid_i = 1'b0; data_rdata_i = $urandom; data_err_i = 1'b1;
        #1;
        check($sformatf("v%0d_resp", idx), {resp_valid_o, resp_we_o, resp_err_o, resp_rdata_o},
              {1'b1, v.we, v.exp_err, v.exp_rd});
        check($sformatf("v%0d_out0", idx), outstanding_o, 0);
        @(negedge clk_i);
        #1;
        check($sformatf("v%0d_resp_hold", idx), {resp_valid_o, resp_rdata_o}, {1'b0, v.exp_rd});
    endtask

    task automatic drive_load(input logic [31:0] addr);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_type_i = 2'b00; req_sign_ext_i = 2'b00;
        req_addr_i = addr;
    endtask

    typedef struct {
        int          due;
        logic [31:0] wa;
    } beat_t;

    beat_t       pend[$];
    logic [33:0] expq[$];

    task automatic run_random(input int nreq);
        int          remaining = nreq;
        int          cyc = 0;
        bit          active = 1'b0;
        logic        cwe = 1'b0;
        logic [1:0]  ctyp = 2'b00;
        logic [1:0]  csext = 2'b00;
        logic [31:0] caddr = 32'd0;
        logic [31:0] cwd = 32'd0;
        logic [33:0] cexp = '0;
        logic [31:0] lane_off;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        beat_t       b;
        pend.delete();
        expq.delete();
        while ((remaining > 0 || active || pend.size() != 0 || expq.size() != 0) && cyc < 20000) begin
            @(negedge clk_i);
            if (resp_valid_o) begin
                if (expq.size() == 0) check("rnd_unexpected_resp", resp_valid_o, 1'b0);
                else check("rnd_resp", {resp_we_o, resp_err_o, resp_rdata_o}, expq.pop_front());
            end
            check("rnd_outstanding", outstanding_o, pend.size());
            if (pend.size() != 0 && pend[0].due <= cyc) begin
                b = pend.pop_front();
                data_rvalid_i = 1'b1; data_rdata_i = mem_word(b.wa); data_err_i = err_word(b.wa);
            end else begin
                data_rvalid_i = 1'b0; data_rdata_i = $urandom; data_err_i = 1'($urandom_range(0, 1));
            end
            if (!active && remaining > 0 && $urandom_range(0, 3) != 0) begin
                active = 1'b1;
                cwe    = 1'($urandom_range(0, 1));
                ctyp   = 2'($urandom_range(0, 3));
                csext  = 2'($urandom_range(0, 3));
                caddr  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + $urandom_range(0, 7)
                                                     : 32'h1000 + $urandom_range(0, 255);
                cwd    = $urandom;
                cexp   = model(cwe, ctyp, csext, caddr);
            end
            req_valid_i = active; req_we_i = cwe; req_type_i = ctyp; req_sign_ext_i = csext;
            req_addr_i = caddr; req_wdata_i = cwd;
            data_gnt_i = ($urandom_range(0, 3) != 0);
            #1;
            if (data_req_o && data_gnt_i) begin
                exp_be = 4'b0000;
                exp_wd = 32'd0;
                for (int k = 0; k < 4; k++) begin
                    lane_off = data_addr_o + k - caddr;
                    if (active && lane_off < nbytes(ctyp)) begin
                        exp_be[k] = 1'b1;
                        exp_wd[8*k +: 8] = cwd[8*lane_off[1:0] +: 8];
                    end
                end
                check("rnd_beat_be", data_be_o, exp_be);
                check("rnd_beat_we", data_we_o, cwe);
                if (cwe) check("rnd_beat_wdata", data_wdata_o & bmask(data_be_o), exp_wd & bmask(exp_be));
                b.due = cyc + $urandom_range(1, 4);
                b.wa  = data_addr_o;
                pend.push_back(b);
            end
            if (req_ready_o) begin
                expq.push_back(cexp);
                active = 1'b0;
                remaining--;
            end
            cyc++;
        end
        check("rnd_all_issued", remaining, 0);
        check("rnd_all_answered", expq.size(), 0);
        req_valid_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
    endtask

    initial begin
        //              we    typ    sext   addr          wdata         rd1           e1    rd2           e2    bt a1            be1      a2            be2      exp_wd        exp_rd        err
        vecs[0]  = '{1'b0, 2'b00, 2'b00, 32'h00000100, 32'h00000000, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0, 1, 32'h00000100, 4'b1111, 32'h0,        4'b0000, 32'h00000000, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 2'b10, 2'b01, 32'h00000103, 32'h00000000, 32'h80123456, 1'b0, 32'h00000000, 1'b0, 1, 32'h00000100, 4'b1000, 32'h0,        4'b0000, 32'h00000000, 32'hFFFFFF80, 1'b0};
        vecs[2]  = '{1'b0, 2'b11, 2'b00, 32'h00000103, 32'h00000000, 32'h80123456, 1'b0, 32'h00000000, 1'b0, 1, 32'h00000100, 4'b1000, 32'h0,        4'b0000, 32'h00000000, 32'h00000080, 1'b0};
        vecs[3]  = '{1'b0, 2'b00, 2'b00, 32'h00000101, 32'h00000000, 32'h332211AA, 1'b0, 32'h55667744, 1'b0, 2, 32'h00000100, 4'b1110, 32'h00000104, 4'b0001, 32'h00000000, 32'h44332211, 1'b0};
        vecs[4]  = '{1'b1, 2'b01, 2'b00, 32'h000001FF, 32'h0000BBAA, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 2, 32'h000001FC, 4'b1000, 32'h00000200, 4'b0001, 32'hAA0000BB, 32'h00000000, 1'b0};
        vecs[5]  = '{1'b0, 2'b01, 2'b11, 32'h00000102, 32'h00000000, 32'h8001CCCC, 1'b0, 32'h00000000, 1'b0, 1, 32'h00000100, 4'b1100, 32'h0,        4'b0000, 32'h00000000, 32'hFFFF8001, 1'b0};
        vecs[6]  = '{1'b0, 2'b10, 2'b10, 32'h00000200, 32'h00000000, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1, 32'h00000200, 4'b0001, 32'h0,        4'b0000, 32'h00000000, 32'hFFFFFF78, 1'b0};
        vecs[7]  = '{1'b0, 2'b01, 2'b00, 32'h00001003, 32'h00000000, 32'hAB000000, 1'b0, 32'h000000CD, 1'b1, 2, 32'h00001000, 4'b1000, 32'h00001004, 4'b0001, 32'h00000000, 32'h0000CDAB, 1'b1};
        vecs[8]  = '{1'b0, 2'b00, 2'b00, 32'hFFFFFFFE, 32'h00000000, 32'h2211FFFF, 1'b0, 32'hEEEE4433, 1'b0, 2, 32'hFFFFFFFC, 4'b1100, 32'h00000000, 4'b0011, 32'h00000000, 32'h44332211, 1'b0};
        vecs[9]  = '{1'b1, 2'b00, 2'b00, 32'h00000300, 32'h12345678, 32'h00000000, 1'b1, 32'h00000000, 1'b0, 1, 32'h00000300, 4'b1111, 32'h0,        4'b0000, 32'h12345678, 32'h00000000, 1'b1};
        vecs[10] = '{1'b0, 2'b01, 2'b01, 32'h00000101, 32'h00000000, 32'h00FF7F00, 1'b0, 32'h00000000, 1'b0, 1, 32'h00000100, 4'b0110, 32'h0,        4'b0000, 32'h00000000, 32'hFFFFFF7F, 1'b0};
        vecs[11] = '{1'b1, 2'b10, 2'b00, 32'h00000402, 32'h000000A5, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1, 32'h00000400, 4'b0100, 32'h0,        4'b0000, 32'h00A50000, 32'h00000000, 1'b0};

        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_type_i = 2'b00; req_sign_ext_i = 2'b00;
        req_addr_i = 32'd0; req_wdata_i = 32'd0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        data_err_i = 1'b0; data_rdata_i = 32'd0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("rst_resp", {resp_valid_o, resp_we_o, resp_err_o, resp_rdata_o}, 35'd0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_data_req", data_req_o, 1'b0);

        for (int i = 0; i < 12; i++) apply_vec(i, vecs[i]);

        // Back-to-back loads fill the tracker; the third must wait for the first rvalid.
        @(negedge clk_i); drive_load(32'h400); data_gnt_i = 1'b1; data_rvalid_i = 1'b0; #1;
        check("b2b_req1", {data_req_o, req_ready_o}, 2'b11);
        @(negedge clk_i); drive_load(32'h404); #1;
        check("b2b_req2", {data_req_o, req_ready_o}, 2'b11);
        check("b2b_out1", outstanding_o, 1);
        @(negedge clk_i); drive_load(32'h408); #1;
        check("b2b_stall_a", data_req_o, 1'b0);
        check("b2b_out2", outstanding_o, 2);
        check("b2b_busy", busy_o, 1'b1);
        @(negedge clk_i); #1;
        check("b2b_stall_b", data_req_o, 1'b0);
        @(negedge clk_i); data_rvalid_i = 1'b1; data_err_i = 1'b0; data_rdata_i = 32'h11111111; #1;
        check("b2b_stall_c", data_req_o, 1'b0);
        @(negedge clk_i); data_rdata_i = 32'h22222222; #1;
        check("b2b_resp1", {resp_valid_o, resp_rdata_o}, {1'b1, 32'h11111111});
        check("b2b_req3", {data_req_o, req_ready_o}, 2'b11);
        @(negedge clk_i); req_valid_i = 1'b0; data_rvalid_i = 1'b0; #1;
        check("b2b_resp2", {resp_valid_o, resp_rdata_o}, {1'b1, 32'h22222222});
        check("b2b_out_mid", outstanding_o, 1);
        @(negedge clk_i); data_rvalid_i = 1'b1; data_rdata_i = 32'h33333333; #1;
        check("b2b_gap", resp_valid_o, 1'b0);
        @(negedge clk_i); data_rvalid_i = 1'b0; #1;
        check("b2b_resp3", {resp_valid_o, resp_rdata_o}, {1'b1, 32'h33333333});
        check("b2b_out_end", outstanding_o, 0);

        // Reset with two beats in flight; later rvalids must be ignored.
        @(negedge clk_i); drive_load(32'h500); data_gnt_i = 1'b1;
        @(negedge clk_i); drive_load(32'h504);
        @(negedge clk_i); req_valid_i = 1'b0; data_gnt_i = 1'b0; #1;
        check("rstm_out_pre", outstanding_o, 2);
        rst_i = 1'b1;
        @(negedge clk_i); rst_i = 1'b0; #1;
        check("rstm_out", outstanding_o, 0);
        check("rstm_resp", {resp_valid_o, resp_rdata_o}, 33'd0);
        check("rstm_busy", busy_o, 1'b0);
        @(negedge clk_i); data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFEF00D;
        @(negedge clk_i); #1;
        check("rstm_stray_resp1", resp_valid_o, 1'b0);
        check("rstm_stray_out", outstanding_o, 0);
        @(negedge clk_i); data_rvalid_i = 1'b0; #1;
        check("rstm_stray_resp2", resp_valid_o, 1'b0);

        run_random(300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
